// File: rtl/fft_pkg.sv
// fft_pkg: saturation helpers and radix-2 pair indexing shared by the butterfly stages
package fft_pkg;
  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
  function automatic longint saturate(input longint v, input int w);
    return v > sat_max(w) ? sat_max(w) : v < sat_min(w) ? sat_min(w) : v;
  endfunction
  function automatic int pair_lo(input int b, input int k, input int stride);
    return b * 2 * stride + k;
  endfunction
endpackage

// File: rtl/bf2_scale_sat.sv
// bf2_scale_sat: per-lane optional round-half-up halving followed by saturation with clip flag
module bf2_scale_sat
  import fft_pkg::*;
#(
  parameter int MID       = 17,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [MID-1:0]       v,
  input  logic                        scale,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        clip
);
  logic signed [MID:0] w, s;
  logic signed [63:0]  sl, st;
  always_comb begin
    w    = {v[MID-1], v};
    s    = scale ? (w + (MID+1)'(1)) >>> 1 : w;
    sl   = 64'(s);
    st   = saturate(sl, OUT_WIDTH);
    clip = st != sl;
    y    = OUT_WIDTH'(st);
  end
endmodule

// File: rtl/bf2_stage_param.sv
// bf2_stage_param: parametrised radix-2 butterfly stage with scaling, saturation, overflow count and backpressure
module bf2_stage_param
  import fft_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int NUM       = 16,
  parameter int STRIDE    = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  din_re [NUM],
  input  logic signed [IN_WIDTH-1:0]  din_im [NUM],
  input  logic                        in_valid,
  input  logic                        scale_en,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] dout_re [NUM],
  output logic signed [OUT_WIDTH-1:0] dout_im [NUM],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sat,
  input  logic                        ovf_clr,
  output logic [CNT_WIDTH-1:0]        ovf_cnt
);
  localparam int MID = IN_WIDTH + 1;
  logic signed [MID-1:0] bf_re [NUM], bf_im [NUM];
  logic signed [MID-1:0] s1_re_q [NUM], s1_im_q [NUM], s1_re_d [NUM], s1_im_d [NUM];
  logic signed [OUT_WIDTH-1:0] sc_re [NUM], sc_im [NUM];
  logic signed [OUT_WIDTH-1:0] dout_re_q [NUM], dout_im_q [NUM], dout_re_d [NUM], dout_im_d [NUM];
  logic [NUM-1:0] clip_re, clip_im;
  logic s1_valid_q, s1_valid_d, s1_scale_q, s1_scale_d;
  logic out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic s1_adv, s2_adv, ld1, ld2;
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  for (genvar b = 0; b < NUM / (2 * STRIDE); b++) begin : g_b
    for (genvar k = 0; k < STRIDE; k++) begin : g_k
      localparam int A = pair_lo(b, k, STRIDE);
      localparam int C = A + STRIDE;
      assign bf_re[A] = MID'(din_re[A]) + MID'(din_re[C]);
      assign bf_re[C] = MID'(din_re[A]) - MID'(din_re[C]);
      assign bf_im[A] = MID'(din_im[A]) + MID'(din_im[C]);
      assign bf_im[C] = MID'(din_im[A]) - MID'(din_im[C]);
    end
  end
  for (genvar i = 0; i < NUM; i++) begin : g_l
    bf2_scale_sat #(.MID(MID), .OUT_WIDTH(OUT_WIDTH)) u_re (
      .v(s1_re_q[i]), .scale(s1_scale_q), .y(sc_re[i]), .clip(clip_re[i])
    );
    bf2_scale_sat #(.MID(MID), .OUT_WIDTH(OUT_WIDTH)) u_im (
      .v(s1_im_q[i]), .scale(s1_scale_q), .y(sc_im[i]), .clip(clip_im[i])
    );
  end
  always_comb begin
    s2_adv      = ~out_valid_q | out_ready;
    s1_adv      = ~s1_valid_q | s2_adv;
    in_ready    = s1_adv;
    ld1         = s1_adv & in_valid;
    ld2         = s2_adv & s1_valid_q;
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s1_scale_d  = ld1 ? scale_en : s1_scale_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_sat_d   = s2_adv ? s1_valid_q & (|{clip_re, clip_im}) : out_sat_q;
    for (int i = 0; i < NUM; i++) begin
      s1_re_d[i]   = ld1 ? bf_re[i] : s1_re_q[i];
      s1_im_d[i]   = ld1 ? bf_im[i] : s1_im_q[i];
      dout_re_d[i] = ld2 ? sc_re[i] : dout_re_q[i];
      dout_im_d[i] = ld2 ? sc_im[i] : dout_im_q[i];
    end
    ovf_cnt_d = ovf_clr ? '0
              : (out_valid_q & out_ready & out_sat_q & ~(&ovf_cnt_q)) ? ovf_cnt_q + 1'b1
              : ovf_cnt_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_scale_q  <= 1'b0;
      s1_re_q     <= '{default: '0};
      s1_im_q     <= '{default: '0};
      dout_re_q   <= '{default: '0};
      dout_im_q   <= '{default: '0};
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_scale_q  <= s1_scale_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      dout_re_q   <= dout_re_d;
      dout_im_q   <= dout_im_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  assign dout_re   = dout_re_q;
  assign dout_im   = dout_im_q;
  assign out_valid = out_valid_q;
  assign out_sat   = out_sat_q;
  assign ovf_cnt   = ovf_cnt_q;
endmodule
